// File: rtl/phase_sequencer.sv
// FETCH/DECODE/EXECUTE/WRITE instruction-cycle controller with memory handshake timeout,
// sticky fault and retired-instruction counter. Optional single-step mode: PHASE_SINGLE_STEP_EN.
module phase_sequencer #(
    parameter int STATE_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
`ifdef PHASE_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic               mem_ack,
    input  logic               is_mem_op,
    input  logic               is_halt,
    output logic [STATE_W-1:0] state,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               exec_en,
    output logic               write_en,
    output logic               mem_req,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [STATE_W-1:0] {
        ST_INIT    = STATE_W'(0),
        ST_FETCH   = STATE_W'(1),
        ST_DECODE  = STATE_W'(2),
        ST_EXECUTE = STATE_W'(3),
        ST_WRITE   = STATE_W'(4),
        ST_HALT    = STATE_W'(5),
`ifdef PHASE_SINGLE_STEP_EN
        ST_FAULT   = STATE_W'(6),
        ST_PAUSE   = STATE_W'(7)
`else
        ST_FAULT   = STATE_W'(6)
`endif
    } state_t;

    localparam bit TIMEOUT_ON = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               mem_op_q, mem_op_d;
    logic               run_q;
    logic [COUNT_W-1:0] count_q;
    logic               count_inc;
    logic               run_rise;
    logic               req_c;
    logic               timeout_hit;

`ifdef PHASE_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;
    assign step_rise = step & ~step_q;
`endif

    assign run_rise    = run & ~run_q;
    assign req_c       = (state_q == ST_FETCH) || ((state_q == ST_EXECUTE) && mem_op_q);
    assign timeout_hit = TIMEOUT_ON && (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        mem_op_d  = mem_op_q;
        count_inc = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (run_rise) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack)          state_d = ST_DECODE;
                else if (timeout_hit) state_d = ST_FAULT;
            end
            ST_DECODE: begin
                mem_op_d = is_mem_op & ~is_halt;
                state_d  = is_halt ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (!mem_op_q || mem_ack) state_d = ST_WRITE;
                else if (timeout_hit)     state_d = ST_FAULT;
            end
            ST_WRITE: begin
                count_inc = 1'b1;
`ifdef PHASE_SINGLE_STEP_EN
                state_d = ST_PAUSE;
`else
                state_d = ST_FETCH;
`endif
            end
            ST_HALT: begin
`ifdef PHASE_SINGLE_STEP_EN
                if (run_rise || step_rise) state_d = ST_FETCH;
`else
                if (run_rise) state_d = ST_FETCH;
`endif
            end
`ifdef PHASE_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (run_rise || step_rise) state_d = ST_FETCH;
            end
`endif
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_INIT;
        endcase
    end

    // Any state change clears the counter, covering every entry to FETCH and EXECUTE.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) wait_d = '0;
        else if (req_c)         wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            wait_q   <= '0;
            mem_op_q <= 1'b0;
            run_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            mem_op_q <= mem_op_d;
            run_q    <= run;
            if (count_inc) count_q <= count_q + 1'b1;
        end
    end

`ifdef PHASE_SINGLE_STEP_EN
    always_ff @(posedge clk) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= step;
    end
`endif

    always_comb begin
        state       = state_q;
        fetch_en    = (state_q == ST_FETCH);
        decode_en   = (state_q == ST_DECODE);
        exec_en     = (state_q == ST_EXECUTE);
        write_en    = (state_q == ST_WRITE);
        fault       = (state_q == ST_FAULT);
        mem_req     = req_c;
        instr_count = count_q;
    end

endmodule
